// File: rtl/ring_dwell_sequencer.sv
`default_nettype none
// ============================================================================
// ring_dwell_sequencer: holds each state of a 5-state ring FSM for its dwell,
// for N loops, and flags any divergence of the ring's reported state. Rev 1.0
// ============================================================================
module ring_dwell_sequencer #(
  parameter int NUM_STATES = 5,
  parameter int CNT_W      = 8,
  parameter int LOOP_W     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_cfg_we,
  input  logic [2:0]            i_cfg_addr,
  input  logic [CNT_W-1:0]      i_cfg_data,
  input  logic                  i_start_valid,
  output logic                  o_start_ready,
  input  logic [LOOP_W-1:0]     i_loops,
  input  logic                  i_abort,
  input  logic [2:0]            i_st_in,
  output logic [NUM_STATES-1:0] o_adv,
  output logic                  o_fsm_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_LAST = 3'(NUM_STATES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_dwell [NUM_STATES];
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_exp;
  logic [LOOP_W-1:0] r_loops_left;
  logic              r_err;

  logic              w_idle;
  logic              w_run;
  logic              w_handshake;
  logic              w_match;
  logic              w_issue;
  logic [CNT_W-1:0]  w_dwell_cur;

  assign w_idle      = (r_state == S_IDLE);
  assign w_run       = (r_state == S_RUN);
  assign w_dwell_cur = r_dwell[r_exp];
  // r_exp never leaves 0..4, so ring values 5..7 always read as a mismatch
  assign w_match     = (i_st_in == r_exp);
  assign w_issue     = w_run && !i_abort && w_match && (r_cnt == w_dwell_cur);
  assign w_handshake = i_start_valid && o_start_ready;

  assign o_start_ready = w_idle && !i_abort;
  assign o_adv         = w_issue ? (NUM_STATES'(1) << r_exp) : '0;
  assign o_fsm_en      = w_issue;
  assign o_busy        = w_run;
  assign o_done        = (r_state == S_DONE);
  assign o_err         = r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_loops_left <= '0;
      r_err        <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) begin
        r_dwell[s] <= '0;
      end
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_we && (i_cfg_addr <= c_LAST)) begin
            r_dwell[i_cfg_addr] <= i_cfg_data;
          end
          if (w_handshake) begin
            if (i_st_in != 3'd0) begin
              r_err <= 1'b1;
            end else if (i_loops == '0) begin
              r_state <= S_DONE;
            end else begin
              r_loops_left <= i_loops;
              r_exp        <= '0;
              r_cnt        <= '0;
              r_state      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // abort outranks both the state check and the final strobe
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (!w_match) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt == w_dwell_cur) begin
            r_cnt <= '0;
            if (r_exp == c_LAST) begin
              r_exp        <= '0;
              r_loops_left <= r_loops_left - LOOP_W'(1);
              if (r_loops_left == LOOP_W'(1)) begin
                r_state <= S_DONE;
              end
            end else begin
              r_exp <= r_exp + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ring_dwell_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ring_dwell_sequencer: ring model + timeline reference feeding an event
// scoreboard that a negedge monitor drains on every strobe. Rev 1.0
// ============================================================================
module tb_ring_dwell_sequencer;
  localparam int NS     = 5;
  localparam int K_DONE = 5;
  localparam int K_ERR  = 6;
  localparam int NEVER  = 1 << 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] loops = 4'd0;
  logic       abort = 1'b0;
  logic [2:0] st_in;
  logic [4:0] adv;
  logic       fsm_en, busy, done, err;

  logic [2:0] ring_y;
  logic       ring_rst = 1'b1;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'd0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int m_dwell [NS];

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t sb[$];

  ring_dwell_sequencer #(.NUM_STATES(5), .CNT_W(8), .LOOP_W(4)) dut (
    .clock(clock), .reset(reset),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .i_start_valid(start_valid), .o_start_ready(start_ready),
    .i_loops(loops), .i_abort(abort), .i_st_in(st_in),
    .o_adv(adv), .o_fsm_en(fsm_en), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // The ring under control: advances out of state s when i<s> and enable are high.
  always @(posedge clock) begin
    if (ring_rst) ring_y <= 3'd0;
    else if (fsm_en && ring_y < 3'd5 && adv[ring_y]) ring_y <= (ring_y == 3'd4) ? 3'd0 : ring_y + 3'd1;
  end
  assign st_in = force_en ? force_val : ring_y;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    sb.push_back(e);
  endfunction

  // Timeline: state s is held dwell[s]+1 cycles; strobe on the last of them.
  task automatic expect_run(input int t0, input int nloops, input int st0, input int cut, input int mism);
    int t;
    if (st0 != 0) begin
      push(K_ERR, t0 + 1);
      return;
    end
    t = t0;
    for (int l = 0; l < nloops; l++) begin
      for (int s = 0; s < NS; s++) begin
        t += m_dwell[s] + 1;
        if (t < cut) push(s, t);
      end
    end
    if (t + 1 < cut) push(K_DONE, t + 1);
    if (mism >= 0) push(K_ERR, mism + 1);
  endtask

  // Monitor: pops one expected event whenever the DUT strobes something.
  always @(negedge clock) begin
    int k;
    ev_t e;
    if (!reset) begin
      k = -1;
      check("adv_onehot0", {31'd0, $onehot0(adv)}, 32'd1);
      check("fsm_en_is_or_adv", {31'd0, fsm_en}, {31'd0, |adv});
      for (int s = 0; s < NS; s++) if (adv[s]) k = s;
      if (k < 0 && done) k = K_DONE;
      else if (k < 0 && err) k = K_ERR;
      if (k >= 0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind", k, e.kind);
          check("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d, input bit model);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 8'(d);
    step();
    cfg_we = 1'b0;
    if (model && a < NS) m_dwell[a] = d;
  endtask

  task automatic ring_reset();
    ring_rst = 1'b1;
    step();
    ring_rst = 1'b0;
  endtask

  task automatic run(input int n, input int st0, input int cut_off, input int mism_off);
    int t0, cut, mism;
    t0   = cyc;
    cut  = (cut_off >= 0) ? t0 + cut_off : NEVER;
    mism = (mism_off >= 0) ? t0 + mism_off : -1;
    if (mism >= 0) cut = mism;
    expect_run(t0, n, st0, cut, mism);
    start_valid = 1'b1;
    loops = 4'(n);
    step();
    start_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 2000) begin
      step();
      n++;
    end
    step();
    step();
    check({name, "_events_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    for (int s = 0; s < NS; s++) m_dwell[s] = 0;
    repeat (3) step();
    check("reset_start_ready", {31'd0, start_ready}, 1);
    reset = 1'b0;
    ring_rst = 1'b0;
    step();
    check("rst_start_ready", {31'd0, start_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done_err", {30'd0, done, err}, 0);
    check("rst_adv_en", {26'd0, adv, fsm_en}, 0);

    // all-zero dwell, one loop
    run(1, 0, -1, -1);
    drain("zero_dwell");
    check("ring_home_zero", ring_y, 0);

    // dwell {2,0,1,0,3}, two loops
    cfg_write(0, 2, 1); cfg_write(1, 0, 1); cfg_write(2, 1, 1); cfg_write(3, 0, 1); cfg_write(4, 3, 1);
    run(2, 0, -1, -1);
    drain("table_dwell");
    check("ring_home_table", ring_y, 0);

    // ring not at 0: refused with err
    force_en = 1'b1; force_val = 3'd2;
    run(1, 2, -1, -1);
    check("refuse_start_ready", {31'd0, start_ready}, 1);
    check("refuse_busy", {31'd0, busy}, 0);
    drain("refusal");
    force_en = 1'b0;

    // zero loops
    run(0, 0, -1, -1);
    drain("zero_loops");

    // abort on the third cycle of a dwell-5 run
    for (int s = 0; s < NS; s++) cfg_write(s, 5, 1);
    run(3, 0, 3, -1);
    step(); step();
    abort = 1'b1;
    #1;
    check("abort_adv", {27'd0, adv}, 0);
    check("abort_start_ready", {31'd0, start_ready}, 0);
    step();
    abort = 1'b0;
    check("abort_busy_next", {31'd0, busy}, 0);
    check("abort_no_done", {31'd0, done}, 0);
    drain("abort_mid");
    ring_reset();

    // abort coinciding with the final adv[4]
    for (int s = 0; s < NS; s++) cfg_write(s, 0, 1);
    run(1, 0, 5, -1);
    repeat (4) step();
    abort = 1'b1;
    #1;
    check("abort_last_adv", {27'd0, adv}, 0);
    step();
    abort = 1'b0;
    drain("abort_last");
    ring_reset();

    // abort in IDLE blocks the handshake
    abort = 1'b1; start_valid = 1'b1; loops = 4'd1;
    #1;
    check("idle_abort_ready", {31'd0, start_ready}, 0);
    step();
    start_valid = 1'b0; abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 0);
    drain("idle_abort");

    // ring reports 3 while state 1 is expected
    run(1, 0, -1, 2);
    step();
    force_en = 1'b1; force_val = 3'd3;
    step();
    force_en = 1'b0;
    check("mismatch_busy", {31'd0, busy}, 0);
    drain("mismatch");
    ring_reset();

    // ignored writes: bad address, and a write while busy
    cfg_write(6, 9, 0);
    run(1, 0, -1, -1);
    cfg_write(2, 7, 0);
    drain("write_busy");
    run(1, 0, -1, -1);
    drain("ignored_writes");
    check("ring_home_ignored", ring_y, 0);

    // reset mid-run clears the table
    for (int s = 0; s < NS; s++) cfg_write(s, 3, 1);
    run(3, 0, 6, -1);
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int s = 0; s < NS; s++) m_dwell[s] = 0;
    check("rstrun_start_ready", {31'd0, start_ready}, 1);
    check("rstrun_busy", {31'd0, busy}, 0);
    ring_reset();
    run(1, 0, -1, -1);
    drain("after_reset");
    check("ring_home_after_reset", ring_y, 0);

    // maximum dwell is held without wrap
    cfg_write(2, 255, 1);
    run(1, 0, -1, -1);
    drain("max_dwell");
    check("ring_home_max", ring_y, 0);

    // randomized tables and loop counts
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NS; s++) cfg_write(s, int'($urandom_range(0, 7)), 1);
      run(int'($urandom_range(0, 3)), 0, -1, -1);
      drain("random");
      check("ring_home_random", ring_y, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
